lcd_gray_fifo: RTL and testbench

LCD_GRAY_FIFO -- requirements
Module: lcd_gray_fifo

---
 rtl/lcd_gray_fifo.sv | 133 +++++++++++++
 tb/tb_lcd_gray_fifo.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_gray_fifo.sv
// Camera-to-LCD pixel FIFO: 2-stage RGB565->gray pipeline feeding an inferred RAM FIFO.
// Define LCD_GRAY_FIFO_GRAY_CONV_EN to store 8-bit gray; otherwise raw RGB565 words are stored.
module lcd_gray_fifo #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [15:0]       pix_data,
  output logic              pix_ready,
  input  logic              data_req,
  output logic [15:0]       data_out,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  output logic              underflow
);

`ifdef LCD_GRAY_FIFO_GRAY_CONV_EN
  localparam int unsigned DataW = 8;
`else
  localparam int unsigned DataW = 16;
`endif

  localparam logic [ADDR_W:0] LevelMax = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] One      = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]  wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]  fifo_level_q, fifo_level_d;
  logic [ADDR_W:0]  stored;
  logic             s1_valid_q;
  logic             overflow_q, underflow_q;
  logic [15:0]      data_out_q;
  logic [DataW-1:0] wr_data;
  logic             accept, rd_fire, wr_fire;

  logic [DataW-1:0] mem [DEPTH];

  // Stored count excludes pixels still in the conversion pipeline.
  assign stored    = wr_ptr_q - rd_ptr_q;
  assign pix_ready = (fifo_level_q < LevelMax);
  assign accept    = pix_valid & pix_ready & ~frame_start;
  assign rd_fire   = data_req & (stored != '0) & ~frame_start;
  assign wr_fire   = s1_valid_q & ~frame_start & ~sys_rst;

`ifdef LCD_GRAY_FIFO_GRAY_CONV_EN
  logic [7:0]  s1_r8_q, s1_g8_q, s1_b8_q;
  logic [15:0] y16;

  always_ff @(posedge sys_clk) begin
    if (accept) begin
      s1_r8_q <= {pix_data[15:11], pix_data[15:13]};
      s1_g8_q <= {pix_data[10:5], pix_data[10:9]};
      s1_b8_q <= {pix_data[4:0], pix_data[4:2]};
    end
  end

  // Weights sum to 256, so the weighted sum of 8-bit channels fits in 16 bits.
  always_comb begin
    y16 = 16'd77 * {8'h00, s1_r8_q} + 16'd150 * {8'h00, s1_g8_q} + 16'd29 * {8'h00, s1_b8_q};
    wr_data = 8'(y16 >> 8);
  end
`else
  logic [15:0] s1_pix_q;

  always_ff @(posedge sys_clk) begin
    if (accept) begin
      s1_pix_q <= pix_data;
    end
  end

  assign wr_data = s1_pix_q;
`endif

  always_ff @(posedge sys_clk) begin
    if (wr_fire) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Registered RAM read lands directly in data_out; an empty request returns zero.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      data_out_q <= 16'h0000;
    end else if (rd_fire) begin
      data_out_q <= 16'(mem[rd_ptr_q[ADDR_W-1:0]]);
    end else if (data_req && !frame_start) begin
      data_out_q <= 16'h0000;
    end
  end

  always_comb begin
    fifo_level_d = fifo_level_q;
    unique case ({accept, rd_fire})
      2'b10:   fifo_level_d = fifo_level_q + One;
      2'b01:   fifo_level_d = fifo_level_q - One;
      default: fifo_level_d = fifo_level_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || frame_start) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_level_q <= '0;
      s1_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      s1_valid_q   <= accept;
      fifo_level_q <= fifo_level_d;
      if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + One;
      end
      if (rd_fire) begin
        rd_ptr_q <= rd_ptr_q + One;
      end
      if (pix_valid && !pix_ready) begin
        overflow_q <= 1'b1;
      end
      if (data_req && (stored == '0)) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign data_out   = data_out_q;
  assign fifo_level = fifo_level_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_lcd_gray_fifo.sv
// Directed self-checking bench for lcd_gray_fifo; follows LCD_GRAY_FIFO_GRAY_CONV_EN like the RTL.
module tb_lcd_gray_fifo;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 10;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              frame_start;
  logic              pix_valid;
  logic [15:0]       pix_data;
  logic              pix_ready;
  logic              data_req;
  logic [15:0]       data_out;
  logic [ADDR_W:0]   fifo_level;
  logic              overflow;
  logic              underflow;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_gray_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .data_req    (data_req),
    .data_out    (data_out),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 sys_clk = ~sys_clk;

  // Expected LCD word for a stored pixel in the configured mode.
  function automatic logic [15:0] exp_out(input logic [15:0] p);
`ifdef LCD_GRAY_FIFO_GRAY_CONV_EN
    logic [31:0] r8, g8, b8, y;
    r8 = {24'h0, p[15:11], p[15:13]};
    g8 = {24'h0, p[10:5], p[10:9]};
    b8 = {24'h0, p[4:0], p[4:2]};
    y  = 77 * r8 + 150 * g8 + 29 * b8;
    return {8'h00, y[15:8]};
`else
    return p;
`endif
  endfunction

  function automatic logic [15:0] full_pix(input int i);
    logic [31:0] v;
    v = i * 97 + 3;
    return v[15:0];
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle();
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    data_req    = 1'b0;
    pix_data    = 16'h0000;
  endtask

  task automatic do_reset();
    idle();
    sys_rst = 1'b1;
    step();
    step();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL reset_data_out got %h want 0000", data_out); end
    n_checks++; if (fifo_level !== 11'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", pix_ready); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow got %b want 0", underflow); end
  endtask

  task automatic test_empty();
    do_reset();
    data_req = 1'b1;
    step();
    data_req = 1'b0;
    n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL empty_data_out got %h want 0000", data_out); end
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL empty_underflow got %b want 1", underflow); end
    n_checks++; if (fifo_level !== 11'd0) begin n_fail++; $display("FAIL empty_level got %0d want 0", fifo_level); end
    step();
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL empty_sticky got %b want 1", underflow); end
  endtask

`ifdef LCD_GRAY_FIFO_GRAY_CONV_EN
  task automatic test_conv();
    logic [15:0] pin [4];
    logic [15:0] pexp [4];
    pin  = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F};
    pexp = '{16'h00FF, 16'h004C, 16'h0095, 16'h001C};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1'b1;
      pix_data  = pin[i];
      step();
    end
    idle();
    step();
    data_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (data_out !== pexp[i]) begin
        n_fail++; $display("FAIL conv_%0d got %h want %h", i, data_out, pexp[i]);
      end
    end
    idle();
  endtask
`else
  task automatic test_raw();
    do_reset();
    pix_valid = 1'b1;
    pix_data  = 16'h1234;
    step();
    idle();
    n_checks++; if (fifo_level !== 11'd1) begin n_fail++; $display("FAIL raw_level got %0d want 1", fifo_level); end
    // One cycle after accept the word is still in flight, so a request underflows.
    data_req = 1'b1;
    step();
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL raw_early_underflow got %b want 1", underflow); end
    n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL raw_early_data got %h want 0000", data_out); end
    step();
    data_req = 1'b0;
    n_checks++; if (data_out !== 16'h1234) begin n_fail++; $display("FAIL raw_data got %h want 1234", data_out); end
    n_checks++; if (fifo_level !== 11'd0) begin n_fail++; $display("FAIL raw_level_after got %0d want 0", fifo_level); end
    step();
    n_checks++; if (data_out !== 16'h1234) begin n_fail++; $display("FAIL raw_hold got %h want 1234", data_out); end
  endtask
`endif

  task automatic test_simultaneous();
    logic [15:0] p [15];
    for (int i = 0; i < 15; i++) p[i] = 16'hA000 + 16'(i * 16'h0431);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1'b1;
      pix_data  = p[i];
      step();
    end
    idle();
    step();
    n_checks++; if (fifo_level !== 11'd5) begin n_fail++; $display("FAIL simul_prefill got %0d want 5", fifo_level); end
    for (int k = 0; k < 10; k++) begin
      pix_valid = 1'b1;
      pix_data  = p[k + 5];
      data_req  = 1'b1;
      step();
      n_checks++;
      if (fifo_level !== 11'd5) begin
        n_fail++; $display("FAIL simul_level_%0d got %0d want 5", k, fifo_level);
      end
      n_checks++;
      if (data_out !== exp_out(p[k])) begin
        n_fail++; $display("FAIL simul_order_%0d got %h want %h", k, data_out, exp_out(p[k]));
      end
    end
    idle();
    step();
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL simul_underflow got %b want 0", underflow); end
  endtask

  task automatic test_full_and_wrap();
    do_reset();
    pix_valid = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      pix_data = full_pix(i);
      step();
    end
    n_checks++; if (fifo_level !== 11'd1024) begin n_fail++; $display("FAIL full_level got %0d want 1024", fifo_level); end
    n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", pix_ready); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_overflow_early got %b want 0", overflow); end
    pix_data = 16'hBEEF;
    step();
    idle();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_overflow got %b want 1", overflow); end
    n_checks++; if (fifo_level !== 11'd1024) begin n_fail++; $display("FAIL full_level_after got %0d want 1024", fifo_level); end
    data_req = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      step();
      n_checks++;
      if (data_out !== exp_out(full_pix(i))) begin
        n_fail++; $display("FAIL full_read_%0d got %h want %h", i, data_out, exp_out(full_pix(i)));
      end
    end
    n_checks++; if (fifo_level !== 11'd0) begin n_fail++; $display("FAIL full_drained got %0d want 0", fifo_level); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL full_no_underflow got %b want 0", underflow); end
    // The dropped 1025th pixel must not appear.
    step();
    data_req = 1'b0;
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL full_dropped got %b want 1", underflow); end
    n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL full_dropped_data got %h want 0000", data_out); end
    // Pointers have wrapped once; keep going across the boundary.
    pix_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pix_data = 16'h5A00 + 16'(i * 16'h1111);
      step();
    end
    idle();
    step();
    data_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (data_out !== exp_out(16'h5A00 + 16'(i * 16'h1111))) begin
        n_fail++; $display("FAIL wrap_%0d got %h want %h", i, data_out, exp_out(16'h5A00 + 16'(i * 16'h1111)));
      end
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    data_req = 1'b1;
    step();
    data_req = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pix_data = 16'(i);
      step();
    end
    n_checks++; if (fifo_level !== 11'd300) begin n_fail++; $display("FAIL flush_prefill got %0d want 300", fifo_level); end
    frame_start = 1'b1;
    pix_data    = 16'hFFFF;
    data_req    = 1'b1;
    step();
    idle();
    n_checks++; if (fifo_level !== 11'd0) begin n_fail++; $display("FAIL flush_level got %0d want 0", fifo_level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL flush_overflow got %b want 0", overflow); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL flush_underflow got %b want 0", underflow); end
    n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", pix_ready); end
    step();
    step();
    n_checks++; if (fifo_level !== 11'd0) begin n_fail++; $display("FAIL flush_level_late got %0d want 0", fifo_level); end
    data_req = 1'b1;
    step();
    data_req = 1'b0;
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL flush_not_stored got %b want 1", underflow); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    pix_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pix_data = 16'h0F0F + 16'(i);
      step();
    end
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    idle();
    n_checks++; if (fifo_level !== 11'd0) begin n_fail++; $display("FAIL midrst_level got %0d want 0", fifo_level); end
    step();
    step();
    data_req = 1'b1;
    step();
    data_req = 1'b0;
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL midrst_discard got %b want 1", underflow); end
  endtask

  initial begin
    sys_rst = 1'b1;
    idle();
    test_reset();
    test_empty();
`ifdef LCD_GRAY_FIFO_GRAY_CONV_EN
    test_conv();
`else
    test_raw();
`endif
    test_simultaneous();
    test_full_and_wrap();
    test_flush();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
